// File: rtl/booth_mul_r4_if.sv
// Start/done/clear handshake and operand/result bus between the controller and
// the radix-4 Booth multiplier.
interface booth_mul_r4_if;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        op_done;
    logic [63:0] result;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  op_done, result
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output op_done, result
    );
endinterface

// File: rtl/booth_mul_r4.sv
// Sequential 32x32 signed multiplier, radix-4 Booth, one recoded digit per cycle.
// Sixteen steps over a 67-bit {acc, q, q_1} working register give the 64-bit product.
module booth_mul_r4 (
    input  logic           clk,
    input  logic           reset_n,
    booth_mul_r4_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state;
    logic [31:0] mcand;
    logic [33:0] acc;
    logic [31:0] q;
    logic        q_1;
    logic [3:0]  cnt;
    logic        done_r;

    logic [33:0] m_ext;
    logic [33:0] addend;
    logic [33:0] sum;

    // Booth digit from {q[1], q[0], q_1}; 34 bits leave headroom for +-2M.
    always_comb begin
        m_ext  = {{2{mcand[31]}}, mcand};
        addend = '0;
        case ({q[1:0], q_1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum = acc + addend;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else if (bus.op_clear) begin
            // Clear wins over start and discards any operation in flight.
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.op_start) begin
                        mcand <= bus.multiplicand;
                        q     <= bus.multiplier;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    acc <= {sum[33], sum[33], sum[33:2]};
                    q   <= {sum[1:0], q[31:2]};
                    q_1 <= q[1];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_done = done_r;
    assign bus.result  = done_r ? {acc[31:0], q} : 64'h0;
endmodule

// File: tb/tb_booth_mul_r4.sv
// Self-checking bench for booth_mul_r4: directed corner cases plus random
// signed operands against a plain-multiplication reference.
module tb_booth_mul_r4;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    booth_mul_r4_if bus ();

    booth_mul_r4 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] qv);
        longint a, b;
        a = longint'($signed(m));
        b = longint'($signed(qv));
        return 64'(a * b);
    endfunction

    // All helpers assume they are entered 1 time unit after a rising edge.
    task automatic start_op(input logic [31:0] m, input logic [31:0] qv);
        bus.op_start     = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = qv;
        @(posedge clk); #1;
        bus.op_start     = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.op_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_clear();
        bus.op_clear = 1'b1;
        @(posedge clk); #1;
        bus.op_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.op_start = 1'b0; bus.op_clear = 1'b0;
        bus.multiplicand = '0; bus.multiplier = '0;
        #13;
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.op_done); end
        n_cmp++; if (bus.result !== 64'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", bus.result); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        start_op(32'd3, 32'd5);
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL basic_early_done got %b exp 0", bus.op_done); end
        wait_done(lat);
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL basic_latency got %0d exp 16", lat); end
        n_cmp++; if (bus.result !== 64'hF) begin n_err++; $display("FAIL basic_result got %h exp %h", bus.result, 64'hF); end
        do_clear();
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL basic_clear_done got %b exp 0", bus.op_done); end
        n_cmp++; if (bus.result !== 64'h0) begin n_err++; $display("FAIL basic_clear_result got %h exp 0", bus.result); end
    endtask

    task automatic test_directed();
        logic [31:0] ms [6];
        logic [31:0] qs [6];
        logic [63:0] ex [6];
        int lat;
        ms[0] = 32'hFFFFFFF9; qs[0] = 32'd6;        ex[0] = 64'hFFFFFFFFFFFFFFD6;
        ms[1] = 32'hFFFFFFFF; qs[1] = 32'hFFFFFFFF; ex[1] = 64'h1;
        ms[2] = 32'h80000000; qs[2] = 32'h80000000; ex[2] = 64'h4000000000000000;
        ms[3] = 32'h7FFFFFFF; qs[3] = 32'h80000000; ex[3] = 64'hC000000080000000;
        ms[4] = 32'h0;        qs[4] = 32'hDEADBEEF; ex[4] = 64'h0;
        ms[5] = 32'h7FFFFFFF; qs[5] = 32'h7FFFFFFF; ex[5] = 64'h3FFFFFFF00000001;
        for (int i = 0; i < 6; i++) begin
            start_op(ms[i], qs[i]);
            wait_done(lat);
            n_cmp++; if (lat != 16) begin n_err++; $display("FAIL dir%0d_latency got %0d exp 16", i, lat); end
            n_cmp++; if (bus.result !== ex[i]) begin n_err++; $display("FAIL dir%0d_result got %h exp %h", i, bus.result, ex[i]); end
            do_clear();
        end
    endtask

    task automatic test_protocol();
        int lat;
        logic [63:0] exp_p;
        exp_p = ref_mul(32'h12345678, 32'hFEDCBA98);
        // start held high through EXEC with different operands on the bus
        bus.op_start = 1'b1; bus.multiplicand = 32'h12345678; bus.multiplier = 32'hFEDCBA98;
        @(posedge clk); #1;
        bus.multiplicand = 32'h0BADF00D; bus.multiplier = 32'h00000003;
        wait_done(lat);
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL hold_start_latency got %0d exp 16", lat); end
        n_cmp++; if (bus.result !== exp_p) begin n_err++; $display("FAIL hold_start_result got %h exp %h", bus.result, exp_p); end
        // start still high in DONE must not restart
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (bus.op_done !== 1'b1) begin n_err++; $display("FAIL start_in_done_done got %b exp 1", bus.op_done); end
        n_cmp++; if (bus.result !== exp_p) begin n_err++; $display("FAIL start_in_done_result got %h exp %h", bus.result, exp_p); end
        bus.op_start = 1'b0;
        do_clear();
        // start and clear together in IDLE: stays IDLE
        bus.op_start = 1'b1; bus.op_clear = 1'b1;
        bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(posedge clk); #1;
        bus.op_start = 1'b0; bus.op_clear = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL start_clear_idle_done got %b exp 0", bus.op_done); end
        n_cmp++; if (bus.result !== 64'h0) begin n_err++; $display("FAIL start_clear_idle_result got %h exp 0", bus.result); end
    endtask

    task automatic test_abort();
        int lat;
        start_op(32'h7FFFFFFF, 32'h80000001);
        repeat (7) @(posedge clk);
        #1;
        do_clear();
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b exp 0", bus.op_done); end
        start_op(32'd12, 32'hFFFFFFF4);
        wait_done(lat);
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL abort_latency got %0d exp 16", lat); end
        n_cmp++; if (bus.result !== 64'hFFFFFFFFFFFFFF70) begin n_err++; $display("FAIL abort_result got %h exp %h", bus.result, 64'hFFFFFFFFFFFFFF70); end
        do_clear();
    endtask

    task automatic test_async_reset();
        int lat;
        // reset between edges while DONE shows the asynchronous effect
        start_op(32'd100, 32'd7);
        wait_done(lat);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL areset_done_done got %b exp 0", bus.op_done); end
        n_cmp++; if (bus.result !== 64'h0) begin n_err++; $display("FAIL areset_done_result got %h exp 0", bus.result); end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        // reset mid-EXEC
        start_op(32'hDEADBEEF, 32'h12345678);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.op_done !== 1'b0) begin n_err++; $display("FAIL areset_exec_done got %b exp 0", bus.op_done); end
        n_cmp++; if (bus.result !== 64'h0) begin n_err++; $display("FAIL areset_exec_result got %h exp 0", bus.result); end
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        start_op(32'h00010000, 32'h00010000);
        wait_done(lat);
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL areset_after_latency got %0d exp 16", lat); end
        n_cmp++; if (bus.result !== 64'h0000000100000000) begin n_err++; $display("FAIL areset_after_result got %h exp %h", bus.result, 64'h0000000100000000); end
        do_clear();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] m, qv;
        logic [63:0] e;
        for (int i = 0; i < 1000; i++) begin
            m  = $urandom;
            qv = $urandom;
            if (i % 8 == 0) m  = {{24{m[7]}}, m[7:0]};
            if (i % 8 == 1) qv = {{24{qv[7]}}, qv[7:0]};
            e = ref_mul(m, qv);
            start_op(m, qv);
            wait_done(lat);
            n_cmp++; if (lat != 16) begin n_err++; $display("FAIL rand%0d_latency got %0d exp 16", i, lat); end
            n_cmp++; if (bus.result !== e) begin n_err++; $display("FAIL rand%0d_result %h*%h got %h exp %h", i, m, qv, bus.result, e); end
            do_clear();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_directed();
        test_protocol();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
